// File: rtl/oled_pkg.sv
// Shared OLED widths, scheduler FSM states and the default timeout fill byte.
package oled_pkg;
  localparam int OLED_ROW_W  = 6;
  localparam int OLED_COL_W  = 7;
  localparam int OLED_DATA_W = 8;

  localparam logic [OLED_DATA_W-1:0] OLED_FILL_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } sched_state_e;
endpackage

// File: rtl/oled_source_sched.sv
// Routes OLED driver pixel reads to one of NUM_SRC sources; ack 3 cycles after read with a 1-cycle source.
// Source chosen only at frame start (0,0); a stalled source is cut off after TIMEOUT cycles with FILL.
module oled_source_sched
  import oled_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int FRAMES_PER_SRC = 60,
  parameter int TIMEOUT        = 16,
  parameter logic [OLED_DATA_W-1:0] FILL = OLED_FILL_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read,
  input  logic [OLED_ROW_W-1:0]        row_idx,
  input  logic [OLED_COL_W-1:0]        column_idx,
  output logic [OLED_DATA_W-1:0]       data,
  output logic                         ack,
  output logic [NUM_SRC-1:0]           src_read,
  output logic [OLED_ROW_W-1:0]        src_row_idx,
  output logic [OLED_COL_W-1:0]        src_column_idx,
  input  logic [OLED_DATA_W*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]           src_ack,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_SRC)-1:0]   sel_idx,
  input  logic                         auto_rotate,
  output logic [$clog2(NUM_SRC)-1:0]   cur_src,
  output logic                         frame_start,
  output logic                         timeout_err
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int FC_W  = $clog2(FRAMES_PER_SRC + 1);
  localparam int WC_W  = $clog2(TIMEOUT + 1);

  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(FRAMES_PER_SRC - 1);
  localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(TIMEOUT - 1);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_SRC - 1);

  sched_state_e state, state_nxt;

  logic [FC_W-1:0]        frame_cnt;
  logic [WC_W-1:0]        wait_cnt;
  logic                   pend_vld;
  logic [SRC_W-1:0]       pend_idx;
  logic [OLED_DATA_W-1:0] sel_data;
  logic                   sel_ack;
  logic                   sel_ok;
  logic                   start;
  logic                   boundary;
  logic                   timeout_hit;

  assign start       = (state == IDLE) && read;
  assign boundary    = start && (row_idx == '0) && (column_idx == '0);
  assign sel_ok      = sel_valid && (int'(sel_idx) < NUM_SRC);
  assign timeout_hit = (wait_cnt == WC_MAX);
  assign ack         = (state == RESP);

  // Only the selected source is visible; everything else on the source bus is ignored.
  always_comb begin
    sel_data = '0;
    sel_ack  = 1'b0;
    src_read = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_src == SRC_W'(i)) begin
        sel_data    = src_data[OLED_DATA_W*i +: OLED_DATA_W];
        sel_ack     = src_ack[i];
        src_read[i] = (state == REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (read) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (sel_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data           <= '0;
      src_row_idx    <= '0;
      src_column_idx <= '0;
      wait_cnt       <= '0;
      timeout_err    <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (start) begin
        src_row_idx    <= row_idx;
        src_column_idx <= column_idx;
      end
      if (state == REQ) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        // A real ack on the last allowed cycle beats the timeout.
        if (sel_ack) begin
          data <= sel_data;
        end else if (timeout_hit) begin
          data        <= FILL;
          timeout_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + WC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_src   <= '0;
      pend_vld  <= 1'b0;
      pend_idx  <= '0;
      frame_cnt <= '0;
    end else if (boundary) begin
      if (sel_ok) begin
        cur_src   <= sel_idx;
        pend_vld  <= 1'b0;
        frame_cnt <= '0;
      end else if (pend_vld) begin
        cur_src   <= pend_idx;
        pend_vld  <= 1'b0;
        frame_cnt <= '0;
      end else if (auto_rotate && (frame_cnt == FC_MAX)) begin
        cur_src   <= (cur_src == SRC_LAST) ? '0 : cur_src + SRC_W'(1);
        frame_cnt <= '0;
      end else if (frame_cnt != FC_MAX) begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end else if (sel_ok) begin
      pend_vld <= 1'b1;
      pend_idx <= sel_idx;
    end
  end

endmodule

// File: tb/tb_oled_source_sched.sv
// Directed bench for oled_source_sched: vector table of frame/select reads plus timeout and reset sequences.
module tb_oled_source_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [5:0]  row_idx;
  logic [6:0]  column_idx;
  logic [7:0]  data;
  logic        ack;
  logic [3:0]  src_read;
  logic [5:0]  src_row_idx;
  logic [6:0]  src_column_idx;
  logic [31:0] src_data;
  logic [3:0]  src_ack;
  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic        auto_rotate;
  logic [1:0]  cur_src;
  logic        frame_start;
  logic        timeout_err;

  logic [7:0] src_byte [4];
  int         src_dly  [4];
  int         src_cnt  [4];
  logic [3:0] src_ack_r;
  logic [3:0] ack_force;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oled_source_sched #(
    .NUM_SRC(4), .FRAMES_PER_SRC(2), .TIMEOUT(16), .FILL(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .read(read), .row_idx(row_idx), .column_idx(column_idx),
    .data(data), .ack(ack), .src_read(src_read), .src_row_idx(src_row_idx),
    .src_column_idx(src_column_idx), .src_data(src_data), .src_ack(src_ack),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .auto_rotate(auto_rotate),
    .cur_src(cur_src), .frame_start(frame_start), .timeout_err(timeout_err)
  );

  assign src_data = {src_byte[3], src_byte[2], src_byte[1], src_byte[0]};
  assign src_ack  = src_ack_r | ack_force;

  // Source model: ack src_dly cycles after its src_read strobe; 0 means never ack.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      src_ack_r[i] <= 1'b0;
      if (rst) begin
        src_cnt[i] <= 0;
      end else if (src_read[i] && src_dly[i] == 1) begin
        src_ack_r[i] <= 1'b1;
      end else if (src_read[i] && src_dly[i] > 1) begin
        src_cnt[i] <= src_dly[i] - 1;
      end else if (src_cnt[i] == 1) begin
        src_ack_r[i] <= 1'b1;
        src_cnt[i]   <= 0;
      end else if (src_cnt[i] > 1) begin
        src_cnt[i] <= src_cnt[i] - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one read and follows it to the ack (bounded); leaves the bench 1ns after an edge in IDLE.
  task automatic run_read(input logic [5:0] r, input logic [6:0] c, input logic sv,
                          input logic [1:0] si, input logic ar,
                          output logic [3:0] sr, output logic fs, output logic [1:0] cs,
                          output int lat, output logic [7:0] d);
    read = 1'b1; row_idx = r; column_idx = c;
    sel_valid = sv; sel_idx = si; auto_rotate = ar;
    @(posedge clk); #1;
    read = 1'b0; sel_valid = 1'b0;
    sr = src_read; fs = frame_start; cs = cur_src;
    lat = -1; d = 8'hxx;
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (ack) begin
        lat = cyc;
        d   = data;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [5:0] row;
    logic [6:0] col;
    logic       sel_v;
    logic [1:0] sel_i;
    logic       auto;
    logic [1:0] exp_src;
    logic       exp_fs;
  } vec_t;

  vec_t       vecs [13];
  logic [3:0] sr;
  logic       fs;
  logic [1:0] cs;
  int         lat;
  logic [7:0] d;
  int         ack_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{6'd3, 7'd5, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{6'd3, 7'd6, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0};  // mid-frame select stays pending
    vecs[2]  = '{6'd0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1};  // pending applied at boundary
    vecs[3]  = '{6'd0, 7'd1, 1'b1, 2'd1, 1'b0, 2'd2, 1'b0};
    vecs[4]  = '{6'd0, 7'd0, 1'b1, 2'd3, 1'b1, 2'd3, 1'b1};  // same-cycle select overrides pending 1
    vecs[5]  = '{6'd5, 7'd9, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0};
    vecs[6]  = '{6'd0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1};
    vecs[7]  = '{6'd0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1};  // wrap 3 -> 0
    vecs[8]  = '{6'd0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1};
    vecs[9]  = '{6'd0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1};  // rotation frozen, count saturated
    vecs[10] = '{6'd0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1};
    vecs[11] = '{6'd0, 7'd0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1};
    vecs[12] = '{6'd0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1};

    src_byte[0] = 8'h55; src_byte[1] = 8'hA1; src_byte[2] = 8'hB2; src_byte[3] = 8'hC3;
    for (int i = 0; i < 4; i++) src_dly[i] = 1;
    ack_force = 4'b0;
    rst = 1'b1; read = 1'b0; row_idx = '0; column_idx = '0;
    sel_valid = 1'b0; sel_idx = '0; auto_rotate = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset ack", 32'(ack), 32'h0);
    chk("reset src_read", 32'(src_read), 32'h0);
    chk("reset data", 32'(data), 32'h0);
    chk("reset cur_src", 32'(cur_src), 32'h0);
    chk("reset frame_start", 32'(frame_start), 32'h0);
    chk("reset timeout_err", 32'(timeout_err), 32'h0);
    chk("reset src_row_idx", 32'(src_row_idx), 32'h0);
    chk("reset src_column_idx", 32'(src_column_idx), 32'h0);

    for (int i = 0; i < 13; i++) begin
      run_read(vecs[i].row, vecs[i].col, vecs[i].sel_v, vecs[i].sel_i, vecs[i].auto,
               sr, fs, cs, lat, d);
      chk($sformatf("v%0d cur_src", i), 32'(cs), 32'(vecs[i].exp_src));
      chk($sformatf("v%0d src_read", i), 32'(sr), 32'(4'b0001 << vecs[i].exp_src));
      chk($sformatf("v%0d frame_start", i), 32'(fs), 32'(vecs[i].exp_fs));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d data", i), 32'(d), 32'(src_byte[vecs[i].exp_src]));
      if (i == 0) begin
        chk("v0 src_row_idx", 32'(src_row_idx), 32'd3);
        chk("v0 src_column_idx", 32'(src_column_idx), 32'd5);
        chk("v0 ack one cycle", 32'(ack), 32'h0);
      end
    end

    // Foreign ack every cycle, selected source acks exactly on the last WAIT cycle.
    src_byte[0] = 8'h3C; src_byte[1] = 8'hFF;
    src_dly[0] = 16; ack_force = 4'b0010;
    run_read(6'd7, 7'd7, 1'b0, 2'd0, 1'b0, sr, fs, cs, lat, d);
    ack_force = 4'b0;
    chk("ack on timeout cycle latency", 32'(lat), 32'd18);
    chk("ack on timeout cycle data", 32'(d), 32'h3C);
    chk("ack on timeout cycle err", 32'(timeout_err), 32'h0);

    src_dly[0] = 0;
    run_read(6'd1, 7'd1, 1'b0, 2'd0, 1'b0, sr, fs, cs, lat, d);
    chk("timeout latency", 32'(lat), 32'd18);
    chk("timeout fill data", 32'(d), 32'h00);
    chk("timeout_err set", 32'(timeout_err), 32'h1);

    src_dly[0] = 1;
    run_read(6'd1, 7'd2, 1'b0, 2'd0, 1'b0, sr, fs, cs, lat, d);
    chk("post-timeout data", 32'(d), 32'h3C);
    chk("timeout_err sticky", 32'(timeout_err), 32'h1);

    // Reset while a boundary read to a silent source 2 sits in WAIT.
    src_dly[2] = 0;
    read = 1'b1; row_idx = '0; column_idx = '0; sel_valid = 1'b1; sel_idx = 2'd2;
    @(posedge clk); #1;
    read = 1'b0; sel_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset cur_src", 32'(cur_src), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset ack", 32'(ack), 32'h0);
    chk("midreset src_read", 32'(src_read), 32'h0);
    chk("midreset data", 32'(data), 32'h0);
    chk("midreset cur_src", 32'(cur_src), 32'h0);
    chk("midreset timeout_err", 32'(timeout_err), 32'h0);
    chk("midreset src_row_idx", 32'(src_row_idx), 32'h0);
    chk("midreset src_column_idx", 32'(src_column_idx), 32'h0);
    chk("midreset frame_start", 32'(frame_start), 32'h0);
    ack_seen = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (ack) ack_seen++;
      @(posedge clk); #1;
    end
    chk("abandoned request no ack", 32'(ack_seen), 32'h0);

    src_dly[2] = 1;
    run_read(6'd4, 7'd4, 1'b0, 2'd0, 1'b0, sr, fs, cs, lat, d);
    chk("post-reset src_read", 32'(sr), 32'b0001);
    chk("post-reset latency", 32'(lat), 32'd3);
    chk("post-reset data", 32'(d), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
